// File: rtl/mac_rst_seq_pkg.sv
// Shared types, default parameters and per-state output decode for the
// MAC reset sequencer.
package mac_rst_seq_pkg;

  localparam int DEF_SETTLE_CYCLES  = 64;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_MAX_RETRY      = 3;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_TX_WAIT = 3'd1,
    ST_RX_WAIT = 3'd2,
    ST_UP      = 3'd3,
    ST_RETRY   = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  typedef struct packed {
    logic tx_rst;
    logic rx_rst;
    logic link_up;
    logic fail;
  } out_t;

  // Larger of two integers, used to size the shared timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Output levels that belong to each state. Unused encodings fall back to
  // the safe "everything held in reset" pattern.
  function automatic out_t state_outputs(input state_t s);
    out_t o;
    o = '{tx_rst: 1'b1, rx_rst: 1'b1, link_up: 1'b0, fail: 1'b0};
    case (s)
      ST_TX_WAIT: o.tx_rst = 1'b0;
      ST_RX_WAIT: begin
        o.tx_rst = 1'b0;
        o.rx_rst = 1'b0;
      end
      ST_UP: begin
        o.tx_rst  = 1'b0;
        o.rx_rst  = 1'b0;
        o.link_up = 1'b1;
      end
      ST_FAIL: o.fail = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Shared up-counter for settle and timeout intervals. The owner clears it on
// every state change and reads o_done when the count reaches i_terminal.
module rst_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_terminal,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // Count register: clear has priority over enable; holds when idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, independent of block ordering.
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_done = (r_count == i_terminal);

endmodule

// File: rtl/mac_reset_sequencer.sv
// Sequences TX then RX reset release to the MAC/PCS once the upstream delayed
// ready is stable, with timeout, bounded retry, sticky fail and SW restart.
module mac_reset_sequencer
  import mac_rst_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ready_in,
  input  logic                             sw_restart,
  input  logic                             tx_ready,
  input  logic                             rx_ready,
  output logic                             tx_rst,
  output logic                             rx_rst,
  output logic                             link_up,
  output logic                             fail,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
);

  localparam int CNT_W = $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] SETTLE_TERM  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX    = RTY_W'(MAX_RETRY);

  state_t           r_state;
  state_t           w_next_state;
  logic [RTY_W-1:0] r_retry_cnt;
  logic [RTY_W-1:0] w_retry_nxt;
  out_t             r_out;

  logic             w_fresh_start;
  logic             w_timer_clear;
  logic             w_timer_en;
  logic             w_timer_done;
  logic [CNT_W-1:0] w_timer_term;

  // Loss of upstream ready or a SW request restarts the whole bring-up and
  // forgets previous timeouts.
  assign w_fresh_start = !ready_in || sw_restart;

  // Terminal count: settle interval in RESET/RETRY, handshake timeout in the
  // wait states.
  always_comb begin
    w_timer_term = SETTLE_TERM;
    if (r_state == ST_TX_WAIT || r_state == ST_RX_WAIT) begin
      w_timer_term = TIMEOUT_TERM;
    end
  end

  // Timer restarts on any state change or fresh start; it only runs in the
  // states that measure an interval, so it stops at the terminal value.
  assign w_timer_clear = w_fresh_start || (w_next_state != r_state);
  assign w_timer_en    = (r_state == ST_RESET)   || (r_state == ST_TX_WAIT) ||
                         (r_state == ST_RX_WAIT) || (r_state == ST_RETRY);

  rst_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_timer_clear),
    .i_enable   (w_timer_en),
    .i_terminal (w_timer_term),
    .o_done     (w_timer_done)
  );

  // Next-state logic: fresh start dominates, then per-state transitions.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_next_state = r_state;
    if (w_fresh_start) begin
      w_next_state = ST_RESET;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (w_timer_done) w_next_state = ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          // Handshake is checked before the timeout so a late ready wins.
          if (tx_ready)          w_next_state = ST_RX_WAIT;
          else if (w_timer_done) w_next_state = ST_RETRY;
        end
        ST_RX_WAIT: begin
          // Losing TX ready while waiting for RX counts as a timeout.
          if (!tx_ready)         w_next_state = ST_RETRY;
          else if (rx_ready)     w_next_state = ST_UP;
          else if (w_timer_done) w_next_state = ST_RETRY;
        end
        ST_UP: begin
          if (!tx_ready || !rx_ready) w_next_state = ST_RETRY;
        end
        ST_RETRY: begin
          // The count was bumped on entry; reaching the limit gives up.
          if (r_retry_cnt == RETRY_MAX) w_next_state = ST_FAIL;
          else if (w_timer_done)        w_next_state = ST_TX_WAIT;
        end
        ST_FAIL: begin
          w_next_state = ST_FAIL;
        end
        default: w_next_state = ST_RESET;
      endcase
    end
  end

  // Retry counter: cleared on fresh start, bumped once per entry into RETRY,
  // saturating at the limit. Deliberately kept across UP.
  always_comb begin
    w_retry_nxt = r_retry_cnt;
    if (w_fresh_start) begin
      w_retry_nxt = '0;
    end else if ((w_next_state == ST_RETRY) && (r_state != ST_RETRY) &&
                 (r_retry_cnt != RETRY_MAX)) begin
      w_retry_nxt = r_retry_cnt + 1'b1;
    end
  end

  // State, retry count and outputs registered together; outputs decode the
  // next state so they move on the same edge as the state.
  always_ff @(posedge clk) begin
    // NOTE: the output register resets to the RESET-state decode, so both
    // MAC resets are asserted from the very first reset edge.
    if (rst) begin
      r_state     <= ST_RESET;
      r_retry_cnt <= '0;
      r_out       <= state_outputs(ST_RESET);
    end else begin
      r_state     <= w_next_state;
      r_retry_cnt <= w_retry_nxt;
      r_out       <= state_outputs(w_next_state);
    end
  end

  assign tx_rst    = r_out.tx_rst;
  assign rx_rst    = r_out.rx_rst;
  assign link_up   = r_out.link_up;
  assign fail      = r_out.fail;
  assign retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_mac_reset_sequencer.sv
// Scoreboard bench for mac_reset_sequencer (SETTLE=8, TIMEOUT=16, RETRY=3).
// Stimulus pushes the expected output snapshot for a given edge number; the
// monitor samples on the falling edge and pops entries as their edge arrives.
module tb_mac_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready_in;
  logic       sw_restart;
  logic       tx_ready;
  logic       rx_ready;
  logic       tx_rst;
  logic       rx_rst;
  logic       link_up;
  logic       fail;
  logic [1:0] retry_cnt;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         at;
    string      name;
    logic [5:0] val;
  } exp_t;

  exp_t sb_q[$];

  mac_reset_sequencer #(
    .SETTLE_CYCLES  (8),
    .TIMEOUT_CYCLES (16),
    .MAX_RETRY      (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ready_in   (ready_in),
    .sw_restart (sw_restart),
    .tx_ready   (tx_ready),
    .rx_ready   (rx_ready),
    .tx_rst     (tx_rst),
    .rx_rst     (rx_rst),
    .link_up    (link_up),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s @edge %0d: got tx_rst=%b rx_rst=%b link_up=%b fail=%b retry_cnt=%0d, want tx_rst=%b rx_rst=%b link_up=%b fail=%b retry_cnt=%0d",
               name, cyc, got[5], got[4], got[3], got[2], got[1:0],
               want[5], want[4], want[3], want[2], want[1:0]);
    end
  endtask

  // Expected outputs just after rising edge number 'at'.
  task automatic exp(input int at, input string name, input logic tx, input logic rx,
                     input logic lu, input logic fl, input logic [1:0] rc);
    exp_t e;
    e.at   = at;
    e.name = name;
    e.val  = {tx, rx, lu, fl, rc};
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every entry whose edge has arrived; late entries fail.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() != 0 && sb_q[0].at <= cyc) begin
      e = sb_q.pop_front();
      if (e.at == cyc) begin
        check(e.name, {tx_rst, rx_rst, link_up, fail, retry_cnt}, e.val);
      end else begin
        checks++;
        failures++;
        $display("FAIL %s: expected at edge %0d, monitor reached it at edge %0d", e.name, e.at, cyc);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int b;
    rst        = 1'b1;
    ready_in   = 1'b1;
    sw_restart = 1'b0;
    tx_ready   = 1'b0;
    rx_ready   = 1'b0;
    tick(3);

    // 1. Bring-up: settle 8, TX handshake 3 cycles later, then RX.
    b = cyc;
    exp(b,      "reset_values", 1, 1, 0, 0, 2'd0);
    exp(b + 7,  "settle_end",   1, 1, 0, 0, 2'd0);
    exp(b + 8,  "tx_release",   0, 1, 0, 0, 2'd0);
    exp(b + 10, "tx_wait_hold", 0, 1, 0, 0, 2'd0);
    exp(b + 11, "rx_release",   0, 0, 0, 0, 2'd0);
    exp(b + 12, "link_up",      0, 0, 1, 0, 2'd0);
    rst = 1'b0;
    tick(10);
    tx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b1;
    tick(3);

    // 3. One-cycle rx_ready drop in UP: retry, re-release after 8.
    b = cyc;
    exp(b + 1,  "up_drop_rx",    1, 1, 0, 0, 2'd1);
    exp(b + 8,  "retry_hold",    1, 1, 0, 0, 2'd1);
    exp(b + 9,  "retry_release", 0, 1, 0, 0, 2'd1);
    exp(b + 10, "rx_wait_again", 0, 0, 0, 0, 2'd1);
    exp(b + 11, "up_keeps_cnt",  0, 0, 1, 0, 2'd1);
    rx_ready = 1'b0;
    tick(1);
    rx_ready = 1'b1;
    tick(13);

    // 4. ready_in pulse in RX_WAIT, then 2. three TX timeouts to FAIL.
    b = cyc;
    exp(b + 1,  "retry2",        1, 1, 0, 0, 2'd2);
    exp(b + 9,  "tx_release_r2", 0, 1, 0, 0, 2'd2);
    exp(b + 10, "in_rx_wait",    0, 0, 0, 0, 2'd2);
    exp(b + 11, "rx_wait_hold",  0, 0, 0, 0, 2'd2);
    exp(b + 12, "ready_drop",    1, 1, 0, 0, 2'd0);
    exp(b + 19, "resettle_end",  1, 1, 0, 0, 2'd0);
    exp(b + 20, "tx_release_rs", 0, 1, 0, 0, 2'd0);
    exp(b + 35, "tx_wait_last1", 0, 1, 0, 0, 2'd0);
    exp(b + 36, "timeout1",      1, 1, 0, 0, 2'd1);
    exp(b + 44, "release_to1",   0, 1, 0, 0, 2'd1);
    exp(b + 59, "tx_wait_last2", 0, 1, 0, 0, 2'd1);
    exp(b + 60, "timeout2",      1, 1, 0, 0, 2'd2);
    exp(b + 68, "release_to2",   0, 1, 0, 0, 2'd2);
    exp(b + 84, "timeout3",      1, 1, 0, 0, 2'd3);
    exp(b + 85, "fail_entry",    1, 1, 0, 1, 2'd3);
    exp(b + 95, "fail_hold",     1, 1, 0, 1, 2'd3);
    rx_ready = 1'b0;
    tick(11);
    ready_in = 1'b0;
    tick(1);
    ready_in = 1'b1;
    tx_ready = 1'b0;
    tick(84);

    // 5. sw_restart out of FAIL, normal bring-up.
    b = cyc;
    exp(b + 1,  "sw_restart",       1, 1, 0, 0, 2'd0);
    exp(b + 8,  "restart_settle",   1, 1, 0, 0, 2'd0);
    exp(b + 9,  "restart_tx_rel",   0, 1, 0, 0, 2'd0);
    exp(b + 10, "restart_rx_rel",   0, 0, 0, 0, 2'd0);
    exp(b + 11, "up_after_restart", 0, 0, 1, 0, 2'd0);
    sw_restart = 1'b1;
    tx_ready   = 1'b1;
    rx_ready   = 1'b1;
    tick(1);
    sw_restart = 1'b0;
    tick(12);

    // 6a. tx_ready arrives on the final timeout cycle: handshake wins.
    b = cyc;
    exp(b + 1,  "up_drop_tx",     1, 1, 0, 0, 2'd1);
    exp(b + 9,  "release_6a",     0, 1, 0, 0, 2'd1);
    exp(b + 24, "timeout_edge",   0, 1, 0, 0, 2'd1);
    exp(b + 25, "late_handshake", 0, 0, 0, 0, 2'd1);
    exp(b + 26, "up_6a",          0, 0, 1, 0, 2'd1);
    tx_ready = 1'b0;
    tick(24);
    tx_ready = 1'b1;
    tick(4);

    // 6b. rst while UP.
    b = cyc;
    exp(b + 1, "rst_in_up",    1, 1, 0, 0, 2'd0);
    exp(b + 9, "rst_rerelease", 0, 1, 0, 0, 2'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(12);

    // sw_restart together with ready_in low.
    b = cyc;
    exp(b + 1, "restart_and_drop", 1, 1, 0, 0, 2'd0);
    exp(b + 9, "tx_release_final", 0, 1, 0, 0, 2'd0);
    sw_restart = 1'b1;
    ready_in   = 1'b0;
    tick(1);
    sw_restart = 1'b0;
    ready_in   = 1'b1;
    tick(11);

    tick(2);
    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: expectation for edge %0d never compared", e.name, e.at);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
